// File: rtl/sram_mr1w_pkg.sv
// Shared types and default geometry for the multi-read, single-write SRAM.
package sram_mr1w_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } ctrl_state_e;

    localparam int unsigned DEF_DATA_W = 128;
    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_NUM_RD = 2;

endpackage

// File: rtl/sram_rd_port.sv
// One registered read port with write-first byte bypass and a valid flag.
module sram_rd_port
    import sram_mr1w_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                rd_en_i,
    input  logic [ADDR_W-1:0]   rd_addr_i,
    input  logic [DATA_W-1:0]   mem_data_i,
    input  logic                wr_en_i,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    input  logic [DATA_W-1:0]   wr_data_i,
    input  logic [DATA_W/8-1:0] wr_be_i,
    output logic [DATA_W-1:0]   rd_data_o,
    output logic                rd_valid_o
);

    localparam int unsigned NB = DATA_W / 8;

    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    // Enabled bytes of a colliding write win; the rest come from storage.
    always_comb begin
        merged = mem_data_i;
        if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (wr_be_i[b]) begin
                    merged[b*8 +: 8] = wr_data_i[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en_i;
            if (rd_en_i) begin
                rd_data_q <= merged;
            end
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/sram_mr1w.sv
// Byte-writable SRAM with NUM_RD registered read ports and a post-reset clear sequence.
module sram_mr1w
    import sram_mr1w_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned NUM_RD = DEF_NUM_RD
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     init_busy,
    input  logic                     WE,
    input  logic [ADDR_W-1:0]        WriteAddress,
    input  logic [DATA_W-1:0]        WriteBus,
    input  logic [DATA_W/8-1:0]      WriteBE,
    input  logic [NUM_RD-1:0]        RE,
    input  logic [NUM_RD*ADDR_W-1:0] ReadAddress,
    output logic [NUM_RD*DATA_W-1:0] ReadBus,
    output logic [NUM_RD-1:0]        ReadValid
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned NB    = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    ctrl_state_e       state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              init_busy_q;
    logic              user_wr;
    logic              clr_wr;

    assign user_wr = !reset && (state_q == READY) && WE;
    assign clr_wr  = !reset && (state_q == INIT);

    // Counter parks at zero once READY so it never re-enters the clear sequence.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            init_busy_q <= 1'b1;
        end else if (state_q == INIT) begin
            if (cnt_q == {ADDR_W{1'b1}}) begin
                state_q     <= READY;
                cnt_q       <= '0;
                init_busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + ADDR_W'(1);
            end
        end
    end

    assign init_busy = init_busy_q;

    always_ff @(posedge clock) begin
        if (clr_wr) begin
            mem[cnt_q] <= '0;
        end else if (user_wr) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (WriteBE[b]) begin
                    mem[WriteAddress][b*8 +: 8] <= WriteBus[b*8 +: 8];
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              en;

        assign addr = ReadAddress[p*ADDR_W +: ADDR_W];
        assign en   = RE[p] && (state_q == READY);

        sram_rd_port #(
            .DATA_W(DATA_W),
            .ADDR_W(ADDR_W)
        ) u_rd_port (
            .clk_i     (clock),
            .rst_i     (reset),
            .rd_en_i   (en),
            .rd_addr_i (addr),
            .mem_data_i(mem[addr]),
            .wr_en_i   (user_wr),
            .wr_addr_i (WriteAddress),
            .wr_data_i (WriteBus),
            .wr_be_i   (WriteBE),
            .rd_data_o (ReadBus[p*DATA_W +: DATA_W]),
            .rd_valid_o(ReadValid[p])
        );
    end

endmodule

// File: tb/tb_sram_mr1w.sv
// Self-checking bench for sram_mr1w against a byte-level array model.
module tb_sram_mr1w;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int NR    = 2;
    localparam int DEPTH = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic             init_busy;
    logic             WE;
    logic [AW-1:0]    WriteAddress;
    logic [DW-1:0]    WriteBus;
    logic [DW/8-1:0]  WriteBE;
    logic [NR-1:0]    RE;
    logic [NR*AW-1:0] ReadAddress;
    logic [NR*DW-1:0] ReadBus;
    logic [NR-1:0]    ReadValid;

    sram_mr1w #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .NUM_RD(NR)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .init_busy   (init_busy),
        .WE          (WE),
        .WriteAddress(WriteAddress),
        .WriteBus    (WriteBus),
        .WriteBE     (WriteBE),
        .RE          (RE),
        .ReadAddress (ReadAddress),
        .ReadBus     (ReadBus),
        .ReadValid   (ReadValid)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] exp_data  [NR];
    logic          exp_valid [NR];
    bit            model_ready = 1'b0;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                            input logic [3:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int k = 0; k < 4; k++) if (be[k]) r[k*8 +: 8] = new_w[k*8 +: 8];
        return r;
    endfunction

    // Drive one cycle of inputs, predict read results, advance the model.
    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [3:0] be, input logic [1:0] re,
                         input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        logic [AW-1:0] ra [NR];
        logic [DW-1:0] v;
        ra[0] = ra0;
        ra[1] = ra1;
        reset = 1'b0;
        WE = we;
        WriteAddress = wa;
        WriteBus = wd;
        WriteBE = be;
        RE = re;
        ReadAddress = {ra1, ra0};
        for (int p = 0; p < NR; p++) begin
            if (model_ready && re[p]) begin
                v = model_mem[ra[p]];
                if (we && wa == ra[p]) v = merge(v, wd, be);
                exp_data[p]  = v;
                exp_valid[p] = 1'b1;
            end else begin
                exp_valid[p] = 1'b0;
            end
        end
        if (model_ready && we) model_mem[wa] = merge(model_mem[wa], wd, be);
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 4'h0, 2'b00, '0, '0);
    endtask

    task automatic apply_reset(input logic we, input logic [1:0] re);
        reset = 1'b1;
        WE = we;
        WriteAddress = 4'd9;
        WriteBus = 32'hFFFF_FFFF;
        WriteBE = 4'hF;
        RE = re;
        ReadAddress = {4'd9, 4'd9};
        @(posedge clock);
        #1;
        reset = 1'b0;
        WE = 1'b0;
        RE = '0;
        for (int a = 0; a < DEPTH; a++) model_mem[a] = '0;
        for (int p = 0; p < NR; p++) begin
            exp_data[p]  = '0;
            exp_valid[p] = 1'b0;
        end
        model_ready = 1'b0;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (init_busy === 1'b1 && n < 64) begin
            idle();
            n++;
        end
        model_ready = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        apply_reset(1'b0, 2'b00);
        checks++;
        if (init_busy !== 1'b1 || ReadValid !== 2'b00 || ReadBus !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b valid=%b bus=%h, expected busy=1 valid=00 bus=0",
                     init_busy, ReadValid, ReadBus);
        end
        wait_init(n);
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL init_length: busy cycles=%0d, expected 16", n);
        end
    endtask

    task automatic test_init_zero();
        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b0, '0, '0, 4'h0, 2'b11, AW'(a), AW'(DEPTH - 1 - a));
            checks++;
            if (init_busy !== 1'b0 || ReadValid !== 2'b11 || ReadBus !== '0) begin
                errors++;
                $display("FAIL init_zero a=%0d: busy=%b valid=%b bus=%h, expected 0/11/0",
                         a, init_busy, ReadValid, ReadBus);
            end
        end
    endtask

    task automatic test_byte_merge();
        drive(1'b1, 4'd3, 32'hDEAD_BEEF, 4'hF, 2'b00, '0, '0);
        drive(1'b1, 4'd3, 32'h0000_00AA, 4'h1, 2'b00, '0, '0);
        drive(1'b0, '0, '0, 4'h0, 2'b01, 4'd3, '0);
        checks++;
        if (ReadValid[0] !== 1'b1 || ReadBus[31:0] !== 32'hDEAD_BEAA) begin
            errors++;
            $display("FAIL byte_merge: valid=%b data=%h, expected valid=1 data=deadbeaa",
                     ReadValid[0], ReadBus[31:0]);
        end
        drive(1'b1, 4'd3, 32'h1234_5678, 4'h0, 2'b10, '0, 4'd3);
        checks++;
        if (ReadValid !== 2'b10 || ReadBus[63:32] !== 32'hDEAD_BEAA
            || ReadBus[31:0] !== 32'hDEAD_BEAA) begin
            errors++;
            $display("FAIL zero_be_write: valid=%b bus=%h, expected valid=10 both deadbeaa",
                     ReadValid, ReadBus);
        end
    endtask

    task automatic test_write_first();
        drive(1'b1, 4'd5, 32'h1111_1111, 4'hF, 2'b00, '0, '0);
        drive(1'b1, 4'd5, 32'h1234_5678, 4'hC, 2'b11, 4'd5, 4'd5);
        checks++;
        if (ReadValid !== 2'b11 || ReadBus[31:0] !== 32'h1234_1111
            || ReadBus[63:32] !== 32'h1234_1111) begin
            errors++;
            $display("FAIL write_first: valid=%b bus=%h, expected valid=11 both 12341111",
                     ReadValid, ReadBus);
        end
    endtask

    task automatic test_single_port_stream();
        for (int a = 0; a < 4; a++) drive(1'b1, AW'(a), DW'(a), 4'hF, 2'b00, '0, '0);
        for (int a = 0; a < 4; a++) begin
            drive(1'b0, '0, '0, 4'h0, 2'b01, AW'(a), 4'd7);
            checks++;
            if (ReadValid !== 2'b01 || ReadBus[31:0] !== DW'(a)) begin
                errors++;
                $display("FAIL stream a=%0d: valid=%b data=%h, expected valid=01 data=%h",
                         a, ReadValid, ReadBus[31:0], a);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            drive(1'($urandom), AW'($urandom), $urandom, 4'($urandom), 2'b11,
                  AW'($urandom), AW'($urandom));
            for (int p = 0; p < NR; p++) begin
                checks++;
                if (ReadValid[p] !== 1'b1 || ReadBus[p*DW +: DW] !== exp_data[p]) begin
                    errors++;
                    $display("FAIL back_to_back i=%0d p=%0d: valid=%b data=%h, expected 1 %h",
                             i, p, ReadValid[p], ReadBus[p*DW +: DW], exp_data[p]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom), AW'($urandom), $urandom, 4'($urandom), 2'($urandom),
                  AW'($urandom), AW'($urandom));
            for (int p = 0; p < NR; p++) begin
                checks++;
                if (ReadValid[p] !== exp_valid[p] || ReadBus[p*DW +: DW] !== exp_data[p]) begin
                    errors++;
                    $display("FAIL random i=%0d p=%0d: valid=%b data=%h, expected %b %h",
                             i, p, ReadValid[p], ReadBus[p*DW +: DW], exp_valid[p], exp_data[p]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_init();
        int n;
        apply_reset(1'b0, 2'b00);
        for (int i = 0; i < 7; i++) idle();
        apply_reset(1'b1, 2'b11);
        checks++;
        if (init_busy !== 1'b1 || ReadValid !== 2'b00) begin
            errors++;
            $display("FAIL mid_init_reset: busy=%b valid=%b, expected busy=1 valid=00",
                     init_busy, ReadValid);
        end
        wait_init(n);
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL mid_init_length: busy cycles=%0d, expected 16", n);
        end
        drive(1'b0, '0, '0, 4'h0, 2'b11, 4'd9, 4'd9);
        checks++;
        if (ReadValid !== 2'b11 || ReadBus !== '0) begin
            errors++;
            $display("FAIL mid_init_addr9: valid=%b bus=%h, expected valid=11 bus=0",
                     ReadValid, ReadBus);
        end
    endtask

    task automatic test_reset_mid_ready();
        int n;
        drive(1'b1, 4'd9, 32'hCAFE_F00D, 4'hF, 2'b00, '0, '0);
        drive(1'b0, '0, '0, 4'h0, 2'b11, 4'd9, 4'd9);
        apply_reset(1'b1, 2'b11);
        checks++;
        if (init_busy !== 1'b1 || ReadValid !== 2'b00 || ReadBus !== '0) begin
            errors++;
            $display("FAIL mid_ready_reset: busy=%b valid=%b bus=%h, expected 1/00/0",
                     init_busy, ReadValid, ReadBus);
        end
        wait_init(n);
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL mid_ready_length: busy cycles=%0d, expected 16", n);
        end
        for (int a = 0; a < DEPTH; a += 2) begin
            drive(1'b0, '0, '0, 4'h0, 2'b11, AW'(a), AW'(a + 1));
            checks++;
            if (ReadValid !== 2'b11 || ReadBus !== '0) begin
                errors++;
                $display("FAIL mid_ready_clear a=%0d: valid=%b bus=%h, expected 11/0",
                         a, ReadValid, ReadBus);
            end
        end
    endtask

    task automatic test_init_ignored();
        apply_reset(1'b0, 2'b00);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, AW'($urandom), $urandom, 4'hF, 2'b11, AW'($urandom), AW'($urandom));
            checks++;
            if (ReadValid !== 2'b00 || ReadBus !== '0) begin
                errors++;
                $display("FAIL init_ignored i=%0d: valid=%b bus=%h, expected 00/0",
                         i, ReadValid, ReadBus);
            end
        end
        checks++;
        if (init_busy !== 1'b0) begin
            errors++;
            $display("FAIL init_ignored_done: busy=%b, expected 0", init_busy);
        end
        model_ready = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b0, '0, '0, 4'h0, 2'b11, AW'(a), AW'(a));
            checks++;
            if (ReadValid !== 2'b11 || ReadBus !== '0) begin
                errors++;
                $display("FAIL init_ignored_mem a=%0d: valid=%b bus=%h, expected 11/0",
                         a, ReadValid, ReadBus);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        WE = 1'b0;
        WriteAddress = '0;
        WriteBus = '0;
        WriteBE = '0;
        RE = '0;
        ReadAddress = '0;
        test_reset();
        test_init_zero();
        test_byte_merge();
        test_write_first();
        test_single_port_stream();
        test_back_to_back();
        test_random();
        test_reset_mid_ready();
        test_reset_mid_init();
        test_init_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_mr1w.md
SRAM_MR1W -- requirements
Module: sram_mr1w

Interface
REQ-001 Parameter DATA_W, 128, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, 16, address width; depth SHALL be 2**ADDR_W words.
REQ-003 Parameter NUM_RD, 2, number of independent read ports; SHALL be 1..4.
REQ-004 Port clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 Port reset  input  1  reset, synchronous, active-high.
REQ-006 Port init_busy  output  1  high while the post-reset clear sequence runs.
REQ-007 Port WE  input  1  write enable.
REQ-008 Port WriteAddress  input  ADDR_W  write word address.
REQ-009 Port WriteBus  input  DATA_W  write data.
REQ-010 Port WriteBE  input  DATA_W/8  byte enables; bit k covers WriteBus[8k+7:8k].
REQ-011 Port RE  input  NUM_RD  per-port read enable.
REQ-012 Port ReadAddress  input  NUM_RD*ADDR_W  packed read addresses; port p uses slice [p*ADDR_W +: ADDR_W].
REQ-013 Port ReadBus  output  NUM_RD*DATA_W  packed registered read data; port p uses slice [p*DATA_W +: DATA_W].
REQ-014 Port ReadValid  output  NUM_RD  per-port read data valid.

Function
REQ-015 Controller SHALL have two states: INIT and READY.
REQ-016 INIT: one word per cycle SHALL be written to zero, address 0 up to 2**ADDR_W-1; init_busy=1.
REQ-017 INIT->READY SHALL occur on the cycle after address 2**ADDR_W-1 is cleared; init_busy SHALL drop in that same transition.
REQ-018 During INIT, WE and RE SHALL be ignored: no user write, ReadValid=0.
REQ-019 READY, WE=1: on the clock edge, only bytes with WriteBE[k]=1 SHALL be updated; WE=1 with WriteBE=0 SHALL leave memory unchanged.
REQ-020 READY, RE[p]=1: ReadBus slice p SHALL present the word at ReadAddress slice p exactly one cycle later, with ReadValid[p]=1 in that cycle.
REQ-021 RE[p]=0: ReadValid[p] SHALL be 0 next cycle, and ReadBus slice p SHALL hold its previous value.
REQ-022 Same-cycle write and read to the same address SHALL be write-first: enabled bytes return new data, non-enabled bytes return old stored data.
REQ-023 Any number of read ports SHALL be able to access the same address in one cycle, all returning identical data.
REQ-024 Back-to-back reads on every cycle SHALL be sustained with no bubbles.
REQ-025 Address arithmetic SHALL be unsigned modulo 2**ADDR_W; the init counter SHALL NOT wrap back into INIT.

Reset
REQ-026 reset=1 SHALL force state INIT, clear counter to 0, init_busy=1, ReadValid=0, and ReadBus=0 on the next edge.
REQ-027 reset asserted mid-INIT or mid-READY SHALL restart clearing from address 0; any write presented in the reset cycle SHALL be discarded.
REQ-028 Memory contents SHALL be defined only by the clear sequence, never by reset directly.

Structure
REQ-029 Shared package SHALL hold the state enum (INIT, READY) and the default DATA_W/ADDR_W/NUM_RD constants.
REQ-030 One sub-module, sram_rd_port (registered read, bypass merge, valid flag), SHALL be instantiated NUM_RD times by a generate loop.
REQ-031 Storage SHALL be a single behavioural array; no per-word enable vector.

Verification (bench: DATA_W=32, ADDR_W=4, NUM_RD=2)
REQ-032 Reset 1 cycle, then idle -> init_busy high for exactly 16 cycles; every read afterwards returns 0x00000000.
REQ-033 Write 0xDEADBEEF to addr 3 with BE=0xF, then write 0x000000AA with BE=0x1 -> a read of addr 3 one cycle later returns 0xDEADBEAA, ReadValid=1.
REQ-034 Same cycle: write 0x12345678 BE=0xC to addr 5 (old 0x11111111); port0 and port1 both read addr 5 -> both return 0x12341111 next cycle.
REQ-035 RE=0b01 for 4 consecutive cycles on addrs 0..3 preloaded with 0..3 -> port0 returns 0,1,2,3 on consecutive cycles; ReadValid[1]=0 throughout.
REQ-036 Assert reset at init count 7, then a write in the reset cycle -> init restarts at 0, takes 16 cycles, and the written address reads 0.
REQ-037 Reads and writes issued during INIT -> ReadValid stays 0 and memory reads 0 after INIT.
